// File: rtl/mem_lsu_stage.sv
// Memory-stage load/store unit: issues req/ack bus cycles for loads and stores
// and registers the M/W boundary (PC, ALU result, raw read word, exception).
module mem_lsu_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  mem_type_i,
    input  logic [31:0] alurs_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stall_o,
    output logic        valid_w_o,
    output logic [31:0] pc_w_o,
    output logic [31:0] alurs_w_o,
    output logic [31:0] rd_w_o,
    output logic [1:0]  exc_w_o
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             flush_lat;

    logic        is_mem;
    logic        misal;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        issue;
    logic        ack;
    logic        tmo;
    logic        kill;

    assign is_mem = mem_rd_i | mem_wr_i;

    // Reserved size code 11 falls through to word handling.
    always_comb begin
        be    = 4'b1111;
        wd    = wdata_i;
        misal = |alurs_i[1:0];
        unique case (mem_type_i)
            2'b01: begin
                misal = alurs_i[0];
                be    = alurs_i[1] ? 4'b1100 : 4'b0011;
                wd    = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                misal = 1'b0;
                be    = 4'b0001 << alurs_i[1:0];
                wd    = {4{wdata_i[7:0]}};
            end
            default: ;
        endcase
    end

    assign issue = (state == IDLE) & valid_i & is_mem
                 & ~misal & ~flush_i;
    assign ack   = (state == WAIT) & bus_ack_i;
    assign tmo   = (state == WAIT) & ~bus_ack_i
                 & (cnt == CNT_W'(TIMEOUT - 1));
    assign kill  = flush_lat | flush_i;

    assign stall_o = (state == WAIT) | issue;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (issue) state_n = WAIT;
            WAIT:    if (ack || tmo) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            flush_lat   <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            valid_w_o   <= 1'b0;
            pc_w_o      <= '0;
            alurs_w_o   <= '0;
            rd_w_o      <= '0;
            exc_w_o     <= '0;
        end else if (state == IDLE) begin
            if (!valid_i || flush_i) begin
                valid_w_o <= 1'b0;
            end else if (!is_mem || misal) begin
                pc_w_o    <= pc_i;
                alurs_w_o <= alurs_i;
                rd_w_o    <= '0;
                valid_w_o <= 1'b1;
                exc_w_o   <= !is_mem ? 2'b00 :
                             mem_wr_i ? 2'b10 : 2'b01;
            end else begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= mem_wr_i;
                bus_addr_o  <= {alurs_i[31:2], 2'b00};
                bus_be_o    <= be;
                bus_wdata_o <= wd;
                cnt         <= '0;
                flush_lat   <= 1'b0;
                valid_w_o   <= 1'b0;
            end
        end else if (ack || tmo) begin
            // A killed instruction retires silently, even on timeout.
            bus_req_o <= 1'b0;
            pc_w_o    <= pc_i;
            alurs_w_o <= alurs_i;
            rd_w_o    <= (ack && !bus_we_o) ? bus_rdata_i : '0;
            valid_w_o <= ~kill;
            exc_w_o   <= (kill || ack) ? 2'b00 : 2'b11;
            flush_lat <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (flush_i) flush_lat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Randomized scoreboard bench for mem_lsu_stage; a monitor pops expected
// writeback results whenever valid_w_o is seen.
module tb_mem_lsu_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic        mem_rd_i = 1'b0;
    logic        mem_wr_i = 1'b0;
    logic [1:0]  mem_type_i = '0;
    logic [31:0] alurs_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        stall_o;
    logic        valid_w_o;
    logic [31:0] pc_w_o;
    logic [31:0] alurs_w_o;
    logic [31:0] rd_w_o;
    logic [1:0]  exc_w_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alurs;
        logic [31:0] rd;
        logic [1:0]  exc;
    } wres_t;

    wres_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    mem_lsu_stage #(.TIMEOUT(TMO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
        .mem_type_i(mem_type_i), .alurs_i(alurs_i),
        .wdata_i(wdata_i), .pc_i(pc_i), .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .stall_o(stall_o),
        .valid_w_o(valid_w_o), .pc_w_o(pc_w_o),
        .alurs_w_o(alurs_w_o), .rd_w_o(rd_w_o), .exc_w_o(exc_w_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_w_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_w", 32'(valid_w_o), 32'd0);
            end else begin
                wres_t e;
                e = exp_q.pop_front();
                check("pc_w", pc_w_o, e.pc);
                check("alurs_w", alurs_w_o, e.alurs);
                check("rd_w", rd_w_o, e.rd);
                check("exc_w", 32'(exc_w_o), 32'(e.exc));
            end
        end
    end

    // kind: 0 bubble, 1 non-memory, 2 load, 3 store
    task automatic do_op(input int kind, input logic [1:0] typ,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] pc, input bit fl0,
                         input int ackd, input int fl_at,
                         input logic [31:0] rdata);
        int          sz;
        bit          mem;
        bit          alg;
        bit          bus;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        wres_t       r;
        sz   = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
        mem  = (kind >= 2);
        alg  = (addr % sz) == 0;
        bus  = (kind != 0) && mem && alg && !fl0;
        e_be = 4'((1 << sz) - 1) << (addr % 4);
        e_wd = (sz == 1) ? wd[7:0] * 32'h01010101 :
               (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
        valid_i    = (kind != 0);
        mem_rd_i   = (kind == 2);
        mem_wr_i   = (kind == 3);
        mem_type_i = typ;
        alurs_i    = addr;
        wdata_i    = wd;
        pc_i       = pc;
        flush_i    = fl0;
        r.pc = pc;
        r.alurs = addr;
        r.rd = '0;
        r.exc = 2'b00;
        if (kind != 0 && !fl0) begin
            if (!mem) begin
                exp_q.push_back(r);
            end else if (!alg) begin
                r.exc = (kind == 3) ? 2'b10 : 2'b01;
                exp_q.push_back(r);
            end else if (ackd >= TMO) begin
                r.exc = 2'b11;
                exp_q.push_back(r);
            end else if (fl_at < 0) begin
                r.rd = (kind == 2) ? rdata : '0;
                exp_q.push_back(r);
            end
        end
        @(negedge clk);
        check("stall_issue", 32'(stall_o), 32'(bus));
        check("req_idle", 32'(bus_req_o), 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        if (bus) begin
            for (int w = 0; w < 64; w++) begin
                if (w == ackd) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = rdata;
                end else begin
                    bus_rdata_i = $urandom;
                end
                if (w == fl_at) flush_i = 1'b1;
                @(negedge clk);
                check("stall_wait", 32'(stall_o), 32'd1);
                check("req_wait", 32'(bus_req_o), 32'd1);
                check("bus_we", 32'(bus_we_o), 32'(kind == 3));
                check("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
                check("bus_be", 32'(bus_be_o), 32'(e_be));
                check("bus_wdata", bus_wdata_o, e_wd);
                @(posedge clk);
                #1;
                bus_ack_i = 1'b0;
                flush_i   = 1'b0;
                if (w == ackd || w == TMO - 1) break;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_valid_w"}, 32'(valid_w_o), 32'd0);
        check({tag, "_pc_w"}, pc_w_o, 32'd0);
        check({tag, "_alurs_w"}, alurs_w_o, 32'd0);
        check({tag, "_rd_w"}, rd_w_o, 32'd0);
        check({tag, "_exc_w"}, 32'(exc_w_o), 32'd0);
        check({tag, "_req"}, 32'(bus_req_o), 32'd0);
        check({tag, "_we"}, 32'(bus_we_o), 32'd0);
        check({tag, "_addr"}, bus_addr_o, 32'd0);
        check({tag, "_be"}, 32'(bus_be_o), 32'd0);
        check({tag, "_wdata"}, bus_wdata_o, 32'd0);
    endtask

    initial begin
        #12;
        chk_zero("rst");
        check("rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        do_op(1, 2'b00, 32'h5, 32'h0, 32'h3000, 0, 0, -1, 32'h0);
        do_op(3, 2'b10, 32'h1003, 32'hAB, 32'h3004, 0, 2, -1, 32'h0);
        do_op(2, 2'b01, 32'h2002, 32'h0, 32'h3008, 0, 0, -1,
              32'h12345678);
        do_op(2, 2'b00, 32'h2001, 32'h0, 32'h300C, 0, 0, -1, 32'h0);
        do_op(3, 2'b01, 32'h2001, 32'h0, 32'h3010, 0, 0, -1, 32'h0);
        do_op(2, 2'b00, 32'h4000, 32'h0, 32'h3014, 0, TMO, -1, 32'h0);
        do_op(3, 2'b00, 32'h4008, 32'hCAFE, 32'h3018, 0, 3, 1, 32'h0);
        do_op(1, 2'b00, 32'h77, 32'h0, 32'h301C, 1, 0, -1, 32'h0);

        valid_i    = 1'b1;
        mem_rd_i   = 1'b0;
        mem_wr_i   = 1'b1;
        mem_type_i = 2'b00;
        alurs_i    = 32'h8000;
        pc_i       = 32'h3020;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        mem_wr_i = 1'b0;
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        check("midrst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 300; i++) begin
            int          k;
            int          p;
            int          d;
            int          f;
            logic [31:0] a;
            p = $urandom_range(0, 99);
            k = (p < 10) ? 0 : (p < 35) ? 1 : (p < 65) ? 2 : 3;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            d = $urandom_range(0, TMO + 1);
            f = -1;
            if (d < TMO && $urandom_range(0, 4) == 0)
                f = $urandom_range(0, d);
            do_op(k, 2'($urandom), a, $urandom, $urandom,
                  ($urandom_range(0, 9) == 0), d, f, $urandom);
        end

        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Memory-stage load/store unit, directly upstream of the writeback stage.
- Takes decoded memory ops from the E/M pipeline register and drives a req/ack data bus with store byte-enable and lane generation.
- Registers results into the M/W boundary: PC, ALU result, raw read word and valid.
- Holds the pipeline via stall_o while a bus transaction is outstanding; returns raw aligned words, since load extension happens in writeback.

Parameters:
- TIMEOUT, 255: bus wait cycles before a bus error is declared; 1..255.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- valid_i  input  1  E/M slot holds a live instruction
- mem_rd_i  input  1  instruction is a load
- mem_wr_i  input  1  instruction is a store
- mem_type_i  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
- alurs_i  input  32  ALU result; effective address for loads/stores
- wdata_i  input  32  store data, right-justified
- pc_i  input  32  instruction PC
- flush_i  input  1  kill current/pending instruction (exception/eret)
- bus_req_o  output  1  transaction request
- bus_we_o  output  1  1 = write
- bus_addr_o  output  32  word-aligned address, {alurs[31:2],2'b00}
- bus_be_o  output  4  byte enables
- bus_wdata_o  output  32  lane-replicated store data
- bus_rdata_i  input  32  read data, valid with ack
- bus_ack_i  input  1  transaction complete
- stall_o  output  1  freeze E/M and upstream
- valid_w_o  output  1  W slot valid
- pc_w_o  output  32  to writeback PC input
- alurs_w_o  output  32  to writeback ALU-result input
- rd_w_o  output  32  raw read word to writeback
- exc_w_o  output  2  00 none, 01 AdEL, 10 AdES, 11 bus error

Behaviour:
- Reset (reset=0, async): state IDLE; every output register 0, including valid_w_o, pc_w_o, alurs_w_o, rd_w_o, exc_w_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o; counter 0.
- States: IDLE, WAIT.
- Alignment: word access requires addr[1:0]=00; halfword access requires addr[0]=0; byte access is always aligned.
- IDLE, non-memory op (valid_i=1, mem_rd_i=mem_wr_i=0):
  - At the next edge: W regs <= pc_i and alurs_i; rd_w_o <= 0; valid_w_o <= 1; exc_w_o <= 00.
  - Latency 1 cycle; stall_o=0.
- IDLE, misaligned memory op:
  - No bus request.
  - W regs loaded as above with exc_w_o <= 01 (load) or 10 (store); latency 1 cycle.
- IDLE, aligned memory op, flush_i=0:
  - stall_o=1 combinationally in this cycle.
  - At the edge: bus_req_o <= 1, bus_we_o <= mem_wr_i; address, be and wdata registered; counter <= 0; valid_w_o <= 0; enter WAIT.
- Byte enables:
  - word: 1111.
  - half: addr[1]? 1100 : 0011; wdata = {2{wdata_i[15:0]}}.
  - byte: 0001 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - Loads use the same be pattern.
- WAIT:
  - stall_o=1; bus outputs held stable until ack.
  - On bus_ack_i=1: bus_req_o <= 0; rd_w_o <= bus_rdata_i (0 for stores); pc/alurs written to W; valid_w_o <= 1; exc 00; return to IDLE. stall_o drops in the cycle after ack.
  - Minimum memory-op latency is 2 cycles (ack in the first WAIT cycle).
  - Without ack, the counter increments each cycle. When counter == TIMEOUT-1 and no ack: drop req, valid_w_o <= 1, exc_w_o <= 11, return to IDLE.
  - Ack and timeout in the same cycle: ack wins.
- Flush:
  - In IDLE: the edge loads valid_w_o <= 0 and starts no request.
  - In WAIT: the transaction is not aborted (a write must complete). The flush is latched; on completion valid_w_o <= 0 and exc_w_o <= 00.
- Upstream contract: upstream holds valid_i/data stable while stall_o=1.
- valid_i=0 in IDLE: valid_w_o <= 0; other W regs are don't-care but are held.
- Reset asserted in WAIT: immediate return to IDLE with bus_req_o=0; the in-flight transaction is abandoned.

Test Plan:
- Non-mem op, pc_i=0x3000, alurs_i=5 -> next cycle valid_w_o=1, pc_w_o=0x3000, alurs_w_o=5, stall_o=0, no bus_req_o.
- sb, addr=0x1003, wdata_i=0x000000AB, ack 3 cycles later -> bus_addr_o=0x1000, be=1000, wdata=0xABABABAB; stall_o high 4 cycles; valid_w_o=1 after ack.
- lh, addr=0x2002, ack in first WAIT cycle with rdata=0x12345678 -> be=1100; rd_w_o=0x12345678 two cycles after issue.
- lw, addr=0x2001 -> no request; exc_w_o=01 next cycle. sh at 0x2001 -> exc_w_o=10.
- TIMEOUT=4, no ack -> req high exactly 4 cycles; exc_w_o=11, valid_w_o=1; stall_o released.
- sw in WAIT with flush_i pulsed, then ack -> write completes (req held until ack), valid_w_o=0. Reset pulse mid-WAIT -> bus_req_o=0 immediately, all outputs 0.
